// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_pkg
// Description : Shared types, code offsets and helpers for btn_evt_sched.
//               BTN_RELEASE_EVT_EN adds the release event kind.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_evt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] PRESS_OFS = 8'h00;
    localparam logic [7:0] REL_OFS   = 8'h10;
    localparam logic [7:0] LONG_OFS  = 8'h20;

    // Kind index doubles as priority: lower index is served first.
    localparam int KIND_PRESS = 0;
    localparam int KIND_LONG  = 1;
    localparam int KIND_REL   = 2;

`ifdef BTN_RELEASE_EVT_EN
    localparam int N_KIND = 3;
`else
    localparam int N_KIND = 2;
`endif

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_evt_track.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_track
// Description : Per-button edge detect, hold counter and pending event flags.
//               BTN_RELEASE_EVT_EN adds the release flag.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_evt_track
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYC = 10,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_armed,
    input  logic              i_lvl,
    input  logic [N_KIND-1:0] i_clr,
    output logic [N_KIND-1:0] o_pend,
    output logic              o_ovf_evt
);

    logic              r_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_KIND-1:0] r_pend;
    logic [N_KIND-1:0] w_set;

    always_comb begin
        w_set             = '0;
        w_set[KIND_PRESS] = i_armed & i_lvl & ~r_prev;
        w_set[KIND_LONG]  = i_armed & i_lvl & (r_cnt == CNT_W'(LONG_CYC - 1));
`ifdef BTN_RELEASE_EVT_EN
        w_set[KIND_REL]   = i_armed & ~i_lvl & r_prev;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= i_lvl;
            if (!i_lvl)
                r_cnt <= '0;
            else if (r_cnt != CNT_W'(LONG_CYC))
                r_cnt <= r_cnt + CNT_W'(1);
            // A set in the same cycle as a grant keeps the flag up.
            r_pend <= (r_pend & ~i_clr) | w_set;
        end
    end

    assign o_pend    = r_pend;
    assign o_ovf_evt = |(w_set & r_pend & ~i_clr);

endmodule
`default_nettype wire

// File: rtl/btn_evt_sched.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_sched
// Description : Round-robin scheduler of button events onto a byte channel.
//               BTN_RELEASE_EVT_EN enables release events.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_evt_sched
    import btn_evt_pkg::*;
#(
    parameter int         N_BTN     = 4,
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         LONG_MS   = 1000,
    parameter logic [7:0] BASE_CODE = 8'h41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_lvl,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic [N_BTN-1:0] pend,
    output logic             ovf
);

    localparam int c_long_cyc = (CLK_HZ / 1000) * LONG_MS;
    localparam int c_cnt_w    = clog2(c_long_cyc + 1);
    localparam int c_rr_w     = (N_BTN > 1) ? clog2(N_BTN) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_armed;
    logic                r_ovf;
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic [c_rr_w-1:0]   r_rr;

    logic [N_KIND-1:0]   w_flags [N_BTN];
    logic [N_KIND-1:0]   w_clr   [N_BTN];
    logic [N_BTN-1:0]    w_ovf_evt;
    logic                w_any;
    logic                w_grant;
    logic [c_rr_w-1:0]   w_sel;
    logic [1:0]          w_kind;
    logic [7:0]          w_ofs;
    logic [7:0]          w_code;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            btn_evt_track #(
                .LONG_CYC (c_long_cyc),
                .CNT_W    (c_cnt_w)
            ) u_track (
                .clk       (clk),
                .rst       (rst),
                .i_armed   (r_armed),
                .i_lvl     (btn_lvl[i]),
                .i_clr     (w_clr[i]),
                .o_pend    (w_flags[i]),
                .o_ovf_evt (w_ovf_evt[i])
            );
            assign pend[i] = |w_flags[i];
        end
    endgenerate

    // Scan starts one past the last winner so every button gets a turn.
    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_sel  = '0;
        w_kind = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(r_rr) + 1 + k;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (!w_any && (|w_flags[idx])) begin
                w_any = 1'b1;
                w_sel = c_rr_w'(idx);
                for (int j = N_KIND - 1; j >= 0; j--)
                    if (w_flags[idx][j]) w_kind = 2'(j);
            end
        end
    end

    always_comb begin
        case (w_kind)
            2'(KIND_LONG): w_ofs = LONG_OFS;
            2'(KIND_REL):  w_ofs = REL_OFS;
            default:       w_ofs = PRESS_OFS;
        endcase
        w_code = BASE_CODE + w_ofs + 8'(w_sel);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            w_clr[i] = '0;
            for (int j = 0; j < N_KIND; j++)
                w_clr[i][j] = w_grant && (w_sel == c_rr_w'(i)) && (w_kind == 2'(j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_rr       <= '0;
        end else begin
            r_armed <= 1'b1;
            r_ovf   <= r_ovf | (|w_ovf_evt);
            if (w_grant) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_code;
                r_rr       <= w_sel;
            end else if ((r_state == SEND) && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire
